fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage upstream of the single-cycle datapath. Owns the PC,
//  computes next-PC (sequential, branch, jump), fetches words from a multi-cycle
//  instruction memory over a req/ack handshake, and presents them to the
//  datapath with a valid/ready handshake. Replaces the free-running PC + ROM pair.
// PARAMETERS
//  RESET_PC  32'h0  byte address fetched first after reset; bits [1:0] forced to 0
//  ADDR_W    8      word-address width of imem_addr
//  TIMEOUT   15     max WAIT cycles without ack before error; 0 = timeout disabled
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-low reset
//  imem_req     out  1       fetch request; held high until ack
//  imem_addr    out  ADDR_W  word address = pc_next[ADDR_W+1:2]
//  imem_ack     in   1       memory data valid this cycle
//  imem_rdata   in   32      instruction word, sampled when imem_ack=1
//  instr        out  32      instruction to decoder
//  instr_valid  out  1       instr/pc valid
//  instr_ready  in   1       datapath executes instr this cycle; branch/jump valid
//  branch       in   1       decoder Branch
//  zero         in   1       ALU Zero
//  jump         in   1       decoder Jump
//  imm          in   16      I-type immediate (branch offset, words)
//  jaddr        in   26      J-type target field
//  pc           out  32      byte address of instr
//  fetch_err    out  1       sticky imem timeout flag
// BEHAVIOUR
//  - Reset (async, reset=0): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=
//    RESET_PC[ADDR_W+1:2], instr=0, instr_valid=0, fetch_err=0, wait cnt=0.
//    Asserting reset mid-operation aborts; imem_req falls without waiting for clk.
//  - All outputs registered. States IDLE, WAIT, ISSUE, ERR:
//    IDLE : next edge -> WAIT; imem_req<=1, addr=pc word, cnt<=0.
//    WAIT : imem_req, imem_addr held stable. Edge with imem_ack=1: instr<=rdata,
//           instr_valid<=1, imem_req<=0 -> ISSUE. Edge with ack=0: cnt++; if
//           TIMEOUT!=0 and this is the TIMEOUT-th consecutive no-ack edge ->
//           ERR, fetch_err<=1, imem_req<=0.
//    ISSUE: instr, pc stable while instr_ready=0 (no timeout). Edge with
//           instr_ready=1: pc<=next_pc, instr_valid<=0, imem_req<=1,
//           imem_addr<=next_pc[ADDR_W+1:2], cnt<=0 -> WAIT.
//    ERR  : terminal until reset; imem_req=0, instr_valid=0, fetch_err=1.
//  - imem_ack ignored outside WAIT; branch/jump/zero/imm/jaddr only sampled on
//    ISSUE edge with instr_ready=1.
//  - next_pc (32-bit, modulo 2^32 wrap): p4 = pc+4;
//    jump=1         -> {p4[31:28], jaddr, 2'b00}   (jump beats branch)
//    branch&zero    -> p4 + (sign_ext(imm) << 2)
//    otherwise      -> p4
//  - imem_addr truncates to ADDR_W bits (wraps inside memory); pc keeps 32 bits.
//  - Throughput: min 2 cycles/instr (ack on first WAIT edge, ready on first
//    ISSUE edge). First instr_valid earliest 2 edges after reset release.
// TESTING
//  1. Release reset, ack 1 cycle after req with 32'h20080005, ready=1 ->
//     imem_addr=0, instr=32'h20080005 valid with pc=0; next imem_addr=1, pc=4.
//  2. pc=0x10, branch=1 zero=1 imm=16'hFFFE -> pc=0x0C, imem_addr=3;
//     repeat with zero=0 -> pc=0x14, imem_addr=5.
//  3. pc=0x10, jump=1 jaddr=26'h40 (branch=1 zero=1 too) -> pc=0x100,
//     imem_addr=8'h40; jump wins.
//  4. Ack delayed 3 cycles, instr_ready low 5 cycles -> req/addr stable during
//     wait, instr/pc stable during ISSUE, pc advances only on ready edge.
//  5. No ack for 15 edges -> fetch_err=1, imem_req=0; later ack ignored;
//     reset low clears fetch_err and refetches RESET_PC.
//  6. Assert reset mid-WAIT between edges -> imem_req=0 and instr_valid=0
//     immediately; pc=RESET_PC; fetch restarts after release.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory req/ack side, datapath valid/ready
// side, and the branch/jump controls fed back from decode.
interface fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              branch;
  logic              zero;
  logic              jump;
  logic [15:0]       imm;
  logic [25:0]       jaddr;
  logic [31:0]       pc;
  logic              fetch_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr, instr_valid, pc, fetch_err,
    input  instr_ready, branch, zero, jump, imm, jaddr
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr, instr_valid, pc, fetch_err,
    output instr_ready, branch, zero, jump, imm, jaddr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory
// port and hands words to the datapath with valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          ADDR_W   = 8,
  parameter int          TIMEOUT  = 15
) (
  input logic           clk,
  input logic           reset,
  fetch_unit_if.master  bus
);

  localparam logic [31:0] PC0   = RESET_PC & ~32'h3;
  localparam int          CW    = $clog2(TIMEOUT + 2);
  localparam bit          TO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, WAIT, ISSUE, ERR
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [31:0] p4;
  logic [31:0] boff;
  logic [31:0] next_pc;

  // Branch offset is in words; jump keeps the p4 region bits.
  assign p4   = pc_q + 32'd4;
  assign boff = {{14{bus.imm[15]}}, bus.imm, 2'b00};

  always_comb begin
    next_pc = p4;
    if (bus.jump)
      next_pc = {p4[31:28], bus.jaddr, 2'b00};
    else if (bus.branch && bus.zero)
      next_pc = p4 + boff;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d = WAIT;
        req_d   = 1'b1;
        addr_d  = pc_q[ADDR_W+1:2];
        cnt_d   = '0;
      end
      WAIT: begin
        if (bus.imem_ack) begin
          state_d = ISSUE;
          instr_d = bus.imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
        end else if (TO_EN && cnt_q == LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
          req_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ISSUE: begin
        if (bus.instr_ready) begin
          state_d = WAIT;
          pc_d    = next_pc;
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = next_pc[ADDR_W+1:2];
          cnt_d   = '0;
        end
      end
      ERR: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= PC0;
      req_q   <= 1'b0;
      addr_q  <= PC0[ADDR_W+1:2];
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential/branch/jump PC, stalls,
// imem timeout and asynchronous reset.
module tb_fetch_unit;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  logic [31:0] cur_pc;

  fetch_unit_if #(.ADDR_W(8)) bus ();

  fetch_unit #(
    .RESET_PC(32'h0),
    .ADDR_W(8),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_up", {31'b0, bus.imem_req}, 32'd1);
  endtask

  task automatic fetch(input int dly,
                       input logic [31:0] data,
                       input logic [31:0] epc);
    wait_req();
    chk("addr", {24'b0, bus.imem_addr}, {24'b0, epc[9:2]});
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("req_hold", {31'b0, bus.imem_req}, 32'd1);
      chk("addr_hold", {24'b0, bus.imem_addr}, {24'b0, epc[9:2]});
      chk("val_lo", {31'b0, bus.instr_valid}, 32'd0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    chk("valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("instr", bus.instr, data);
    chk("pc", bus.pc, epc);
    chk("req_dn", {31'b0, bus.imem_req}, 32'd0);
  endtask

  task automatic issue(input int dly,
                       input logic br, input logic z, input logic j,
                       input logic [15:0] imm,
                       input logic [25:0] ja,
                       input logic [31:0] epc);
    logic [31:0] held;
    held = bus.instr;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("stall_val", {31'b0, bus.instr_valid}, 32'd1);
      chk("stall_pc", bus.pc, cur_pc);
      chk("stall_ins", bus.instr, held);
    end
    bus.instr_ready = 1'b1;
    bus.branch = br;
    bus.zero   = z;
    bus.jump   = j;
    bus.imm    = imm;
    bus.jaddr  = ja;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.branch = 1'b0;
    bus.zero   = 1'b0;
    bus.jump   = 1'b0;
    bus.imm    = 16'h0;
    bus.jaddr  = 26'h0;
    chk("npc", bus.pc, epc);
    chk("naddr", {24'b0, bus.imem_addr}, {24'b0, epc[9:2]});
    chk("nval", {31'b0, bus.instr_valid}, 32'd0);
    chk("nreq", {31'b0, bus.imem_req}, 32'd1);
    cur_pc = epc;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    cur_pc = 32'h0;
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0;
    bus.branch = 1'b0;
    bus.zero = 1'b0;
    bus.jump = 1'b0;
    bus.imm = 16'h0;
    bus.jaddr = 26'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_val", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_addr", {24'b0, bus.imem_addr}, 32'h0);
    chk("rst_err", {31'b0, bus.fetch_err}, 32'd0);
    chk("rst_ins", bus.instr, 32'h0);
    reset = 1'b1;

    // sequential fetch up to pc=0x10
    fetch(0, 32'h2008_0005, 32'h0);
    issue(0, 0, 0, 0, 16'h0, 26'h0, 32'h4);
    fetch(0, 32'h0000_0000, 32'h4);
    issue(0, 0, 0, 0, 16'h0, 26'h0, 32'h8);
    fetch(0, 32'h1111_1111, 32'h8);
    issue(0, 0, 0, 0, 16'h0, 26'h0, 32'hC);
    fetch(0, 32'h2222_2222, 32'hC);
    issue(0, 0, 0, 0, 16'h0, 26'h0, 32'h10);

    // taken branch back, then not-taken
    fetch(0, 32'h1000_FFFE, 32'h10);
    issue(0, 1, 1, 0, 16'hFFFE, 26'h0, 32'hC);
    fetch(0, 32'h3333_3333, 32'hC);
    issue(0, 0, 0, 0, 16'h0, 26'h0, 32'h10);
    fetch(0, 32'h1000_FFFE, 32'h10);
    issue(0, 1, 0, 0, 16'hFFFE, 26'h0, 32'h14);
    fetch(0, 32'h4444_4444, 32'h14);
    issue(0, 1, 1, 0, 16'hFFFE, 26'h0, 32'h10);

    // jump wins over taken branch
    fetch(0, 32'h0800_0040, 32'h10);
    issue(0, 1, 1, 1, 16'hFFFE, 26'h40, 32'h100);

    // slow memory, stalled datapath
    fetch(3, 32'h5555_5555, 32'h100);
    issue(5, 0, 0, 0, 16'h0, 26'h0, 32'h104);

    // imem_addr wraps at ADDR_W bits
    fetch(0, 32'h0800_0101, 32'h104);
    issue(0, 0, 0, 1, 16'h0, 26'h101, 32'h404);
    fetch(1, 32'h6666_6666, 32'h404);
    issue(0, 0, 0, 0, 16'h0, 26'h0, 32'h408);

    // timeout: 14 silent edges survive, the 15th errors
    for (int i = 0; i < 14; i++) @(negedge clk);
    chk("to14_req", {31'b0, bus.imem_req}, 32'd1);
    chk("to14_err", {31'b0, bus.fetch_err}, 32'd0);
    @(negedge clk);
    chk("to15_err", {31'b0, bus.fetch_err}, 32'd1);
    chk("to15_req", {31'b0, bus.imem_req}, 32'd0);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h7777_7777;
    for (int i = 0; i < 3; i++) @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("err_stk", {31'b0, bus.fetch_err}, 32'd1);
    chk("err_val", {31'b0, bus.instr_valid}, 32'd0);
    chk("err_req", {31'b0, bus.imem_req}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("clr_err", {31'b0, bus.fetch_err}, 32'd0);
    chk("clr_pc", bus.pc, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    cur_pc = 32'h0;
    fetch(0, 32'h8888_8888, 32'h0);
    issue(0, 0, 0, 0, 16'h0, 26'h0, 32'h4);

    // async reset in the middle of a WAIT
    #2 reset = 1'b0;
    #1;
    chk("arst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("arst_val", {31'b0, bus.instr_valid}, 32'd0);
    chk("arst_pc", bus.pc, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    cur_pc = 32'h0;
    fetch(1, 32'h9999_9999, 32'h0);
    issue(0, 0, 0, 0, 16'h0, 26'h0, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
